// File: rtl/axi_mem_responder.sv
// AXI4 memory responder with single-beat ATOP support (swap, load-add).
// Serves one transaction at a time from an internal 128-bit word array.
module axi_mem_responder #(
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned MemWords     = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [AxiIdWidth-1:0]   aw_id_i,
    input  logic [AxiAddrWidth-1:0] aw_addr_i,
    input  logic [7:0]              aw_len_i,
    input  logic [5:0]              aw_atop_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [127:0]            w_data_i,
    input  logic [15:0]             w_strb_i,
    input  logic                    w_last_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [AxiIdWidth-1:0]   b_id_o,
    output logic [1:0]              b_resp_o,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [AxiIdWidth-1:0]   ar_id_i,
    input  logic [AxiAddrWidth-1:0] ar_addr_i,
    input  logic [7:0]              ar_len_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [AxiIdWidth-1:0]   r_id_o,
    output logic [127:0]            r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o
);

    localparam int unsigned IdxW = $clog2(MemWords);

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespSlvErr = 2'd2;
    localparam logic [1:0] RespDecErr = 2'd3;

    localparam logic [5:0] AtopSwap  = 6'b110000;
    localparam logic [5:0] AtopLdAdd = 6'b100000;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StBresp,
        StRd,
        StAtw,
        StAtresp
    } state_e;

    state_e                  state_q, state_d;
    logic                    rd_first_q, rd_first_d;
    logic [AxiIdWidth-1:0]   id_q, id_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              beat_q, beat_d;
    logic [5:0]              atop_q, atop_d;
    logic                    b_valid_q, b_valid_d;
    logic [1:0]              b_resp_q, b_resp_d;
    logic                    r_valid_q, r_valid_d;
    logic [127:0]            r_data_q, r_data_d;
    logic [1:0]              r_resp_q, r_resp_d;
    logic                    r_last_q, r_last_d;

    logic [127:0] mem [MemWords];

    logic                    mem_we;
    logic [15:0]             mem_be;
    logic [127:0]            mem_wd;
    logic [IdxW-1:0]         cur_idx;
    logic                    cur_oor, ar_oor, nxt_oor;
    logic [127:0]            cur_word, ar_word, nxt_word;
    logic [AxiAddrWidth-1:0] nxt_addr;
    logic                    gnt_rd, gnt_wr;
    logic                    len_mism, at_ok_op;
    logic [1:0]              at_resp, wr_beat_resp;
    logic [63:0]             old_lane, add_lane, ld_sum;

    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Any address bit above the array span marks the beat as undecoded.
    assign cur_idx  = addr_q[IdxW+3:4];
    assign cur_oor  = |addr_q[AxiAddrWidth-1:IdxW+4];
    assign cur_word = mem[cur_idx];
    assign ar_oor   = |ar_addr_i[AxiAddrWidth-1:IdxW+4];
    assign ar_word  = mem[ar_addr_i[IdxW+3:4]];
    assign nxt_addr = addr_q + AxiAddrWidth'(16);
    assign nxt_oor  = |nxt_addr[AxiAddrWidth-1:IdxW+4];
    assign nxt_word = mem[nxt_addr[IdxW+3:4]];

    assign gnt_rd = ar_valid_i && (!aw_valid_i || rd_first_q);
    assign gnt_wr = aw_valid_i && !gnt_rd;

    assign len_mism     = w_last_i != (beat_q == len_q);
    assign wr_beat_resp = worse(cur_oor ? RespDecErr : RespOkay,
                                len_mism ? RespSlvErr : RespOkay);

    assign at_ok_op = (atop_q == AtopSwap) || (atop_q == AtopLdAdd);
    assign at_resp  = cur_oor ? RespDecErr :
                      (!at_ok_op || len_q != 8'd0) ? RespSlvErr : RespOkay;
    assign old_lane = addr_q[3] ? cur_word[127:64] : cur_word[63:0];
    assign add_lane = addr_q[3] ? w_data_i[127:64] : w_data_i[63:0];
    assign ld_sum   = old_lane + add_lane;

    always_comb begin
        state_d    = state_q;
        rd_first_d = rd_first_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        atop_d     = atop_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        r_last_d   = r_last_q;
        aw_ready_o = 1'b0;
        ar_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_wd     = '0;
        case (state_q)
            StIdle: begin
                if (!rst_i && gnt_rd) begin
                    ar_ready_o = 1'b1;
                    rd_first_d = 1'b0;
                    id_d       = ar_id_i;
                    addr_d     = ar_addr_i;
                    len_d      = ar_len_i;
                    beat_d     = 8'd0;
                    r_valid_d  = 1'b1;
                    r_data_d   = ar_oor ? '0 : ar_word;
                    r_resp_d   = ar_oor ? RespDecErr : RespOkay;
                    r_last_d   = ar_len_i == 8'd0;
                    state_d    = StRd;
                end else if (!rst_i && gnt_wr) begin
                    aw_ready_o = 1'b1;
                    rd_first_d = 1'b1;
                    id_d       = aw_id_i;
                    addr_d     = aw_addr_i;
                    len_d      = aw_len_i;
                    beat_d     = 8'd0;
                    atop_d     = aw_atop_i;
                    b_resp_d   = RespOkay;
                    state_d    = (aw_atop_i == 6'd0) ? StWr : StAtw;
                end
            end
            StWr: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    mem_we   = !cur_oor;
                    mem_be   = w_strb_i;
                    mem_wd   = w_data_i;
                    b_resp_d = worse(b_resp_q, wr_beat_resp);
                    addr_d   = nxt_addr;
                    beat_d   = beat_q + 8'd1;
                    if (w_last_i) begin
                        b_valid_d = 1'b1;
                        state_d   = StBresp;
                    end
                end
            end
            StBresp: begin
                if (b_ready_i) begin
                    b_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StRd: begin
                if (r_ready_i) begin
                    if (r_last_q) begin
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        addr_d   = nxt_addr;
                        beat_d   = beat_q + 8'd1;
                        r_data_d = nxt_oor ? '0 : nxt_word;
                        r_resp_d = nxt_oor ? RespDecErr : RespOkay;
                        r_last_d = (beat_q + 8'd1) == len_q;
                    end
                end
            end
            StAtw: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    if (at_resp == RespOkay) begin
                        mem_we = 1'b1;
                        if (atop_q == AtopSwap) begin
                            mem_be = w_strb_i;
                            mem_wd = w_data_i;
                        end else begin
                            mem_be = addr_q[3] ? 16'hFF00 : 16'h00FF;
                            mem_wd = {ld_sum, ld_sum};
                        end
                    end
                    b_valid_d = 1'b1;
                    b_resp_d  = at_resp;
                    r_valid_d = atop_q[5];
                    r_resp_d  = at_resp;
                    r_last_d  = atop_q[5];
                    r_data_d  = (at_resp == RespOkay) ? cur_word : '0;
                    state_d   = StAtresp;
                end
            end
            StAtresp: begin
                if (b_ready_i) b_valid_d = 1'b0;
                if (r_ready_i) r_valid_d = 1'b0;
                if (!b_valid_d && !r_valid_d) begin
                    r_last_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rd_first_q <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            atop_q     <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            r_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_first_q <= rd_first_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            atop_q     <= atop_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 16; b++) begin
            if (mem_we && mem_be[b]) mem[cur_idx][b*8 +: 8] <= mem_wd[b*8 +: 8];
        end
    end

    assign b_valid_o = b_valid_q;
    assign b_id_o    = id_q;
    assign b_resp_o  = b_resp_q;
    assign r_valid_o = r_valid_q;
    assign r_id_o    = id_q;
    assign r_data_o  = r_data_q;
    assign r_resp_o  = r_resp_q;
    assign r_last_o  = r_last_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomised bench for axi_mem_responder against a word-array reference.
// Expected responses come from plain address arithmetic over ref_mem.
module tb_axi_mem_responder;

    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst;
    logic aw_valid, aw_ready;
    logic [3:0] aw_id;
    logic [63:0] aw_addr;
    logic [7:0] aw_len;
    logic [5:0] aw_atop;
    logic w_valid, w_ready;
    logic [127:0] w_data;
    logic [15:0] w_strb;
    logic w_last;
    logic b_valid, b_ready;
    logic [3:0] b_id;
    logic [1:0] b_resp;
    logic ar_valid, ar_ready;
    logic [3:0] ar_id;
    logic [63:0] ar_addr;
    logic [7:0] ar_len;
    logic r_valid, r_ready;
    logic [3:0] r_id;
    logic [127:0] r_data;
    logic [1:0] r_resp;
    logic r_last;

    int total = 0;
    int bad = 0;
    logic [127:0] ref_mem [MW];

    always #5 clk = ~clk;

    axi_mem_responder #(.AxiIdWidth(4), .AxiAddrWidth(64), .MemWords(MW)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
        .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_atop_i(aw_atop),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
        .w_strb_i(w_strb), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
        .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [145:0] all_outs();
        return {aw_ready, ar_ready, w_ready, b_valid, b_id, b_resp,
                r_valid, r_id, r_data, r_resp, r_last};
    endfunction

    task automatic idle_inputs();
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_atop = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; r_ready = 0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [5:0] atop);
        int n = 0;
        @(negedge clk);
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_atop = atop;
        #1;
        while (aw_ready !== 1'b1 && n < 64) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (aw_ready !== 1'b1) begin
            bad++;
            $display("FAIL aw_handshake: ready=%b required 1", aw_ready);
        end
        @(posedge clk); #1;
        aw_valid = 0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [63:0] addr,
                           input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len;
        #1;
        while (ar_ready !== 1'b1 && n < 64) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (ar_ready !== 1'b1) begin
            bad++;
            $display("FAIL ar_handshake: ready=%b required 1", ar_ready);
        end
        @(posedge clk); #1;
        ar_valid = 0;
    endtask

    task automatic w_send(input logic [127:0] d, input logic [15:0] s, input logic l);
        int n = 0;
        @(negedge clk);
        w_valid = 1; w_data = d; w_strb = s; w_last = l;
        #1;
        while (w_ready !== 1'b1 && n < 64) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (w_ready !== 1'b1) begin
            bad++;
            $display("FAIL w_handshake: ready=%b required 1", w_ready);
        end
        @(posedge clk); #1;
        w_valid = 0;
    endtask

    task automatic b_recv(input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        b_ready = 1;
        #1;
        while (b_valid !== 1'b1 && n < 64) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (b_valid !== 1'b1) begin
            bad++;
            $display("FAIL b_timeout: valid=%b required 1", b_valid);
        end else if ({b_id, b_resp} !== {id, resp}) begin
            bad++;
            $display("FAIL b_id_resp: got id=%0d resp=%0d required id=%0d resp=%0d",
                     b_id, b_resp, id, resp);
        end
        @(posedge clk); #1;
        b_ready = 0;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input int nbeats,
                            input bit seq, input bit rstrb);
        logic [1:0] exp;
        logic [63:0] a;
        logic [127:0] d;
        logic [15:0] s;
        exp = 2'd0;
        aw_send(id, addr, len, 6'd0);
        for (int i = 0; i < nbeats; i++) begin
            a = addr + 64'(16 * i);
            d = seq ? 128'(10 + i) : rnd128();
            s = rstrb ? 16'($urandom) : 16'hFFFF;
            w_send(d, s, i == nbeats - 1);
            if (a >= 64'(MW * 16)) exp = 2'd3;
            else
                for (int b = 0; b < 16; b++)
                    if (s[b]) ref_mem[a[13:4]][b*8 +: 8] = d[b*8 +: 8];
        end
        if (nbeats != int'(len) + 1 && exp < 2'd2) exp = 2'd2;
        b_recv(id, exp);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input int mode);
        int k = 0;
        int cyc = 0;
        int stalls = 0;
        bit have_prev = 0;
        logic [134:0] prev, cur;
        logic [63:0] a;
        logic [127:0] ed;
        logic [1:0] er;
        ar_send(id, addr, len);
        total++;
        if (r_valid !== 1'b1) begin
            bad++;
            $display("FAIL r_first_latency: r_valid=%b required 1", r_valid);
        end
        while (k <= int'(len) && cyc < 2000) begin
            @(negedge clk);
            if (mode == 1 && k == 2 && stalls < 3) begin
                r_ready = 0; stalls++;
            end else if (mode == 2) r_ready = 1'($urandom_range(0, 1));
            else r_ready = 1;
            #1;
            cur = {r_data, r_id, r_resp, r_last};
            total++;
            if (r_valid !== 1'b1) begin
                bad++;
                $display("FAIL r_gap: r_valid=%b required 1 at beat %0d", r_valid, k);
            end else begin
                if (have_prev) begin
                    total++;
                    if (cur !== prev) begin
                        bad++;
                        $display("FAIL r_stable: got %h required %h", cur, prev);
                    end
                end
                prev = cur;
                have_prev = !r_ready;
                if (r_ready) begin
                    a = addr + 64'(16 * k);
                    ed = (a >= 64'(MW * 16)) ? 128'd0 : ref_mem[a[13:4]];
                    er = (a >= 64'(MW * 16)) ? 2'd3 : 2'd0;
                    total++;
                    if (r_data !== ed) begin
                        bad++;
                        $display("FAIL r_data beat %0d: got %h required %h", k, r_data, ed);
                    end
                    total++;
                    if ({r_id, r_resp, r_last} !== {id, er, 1'(k == int'(len))}) begin
                        bad++;
                        $display("FAIL r_ctl beat %0d: got id=%0d resp=%0d last=%b required id=%0d resp=%0d last=%b",
                                 k, r_id, r_resp, r_last, id, er, k == int'(len));
                    end
                    k++;
                end
            end
            cyc++;
        end
        @(negedge clk);
        r_ready = 0;
        #1;
        total++;
        if (r_valid !== 1'b0 || k <= int'(len)) begin
            bad++;
            $display("FAIL r_end: r_valid=%b beats=%0d required 0 and %0d", r_valid, k, len + 1);
        end
    endtask

    task automatic atomic_chk(input logic [3:0] id, input logic [63:0] addr,
                              input logic [5:0] atop, input logic [7:0] len,
                              input logic [127:0] wd, input logic [15:0] ws,
                              input logic [1:0] er, input bit exp_r,
                              input logic [127:0] ed);
        int n = 0;
        aw_send(id, addr, len, atop);
        w_send(wd, ws, 1'b1);
        @(negedge clk);
        b_ready = 1; r_ready = 1;
        #1;
        while (b_valid !== 1'b1 && n < 64) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (b_valid !== 1'b1 || r_valid !== exp_r) begin
            bad++;
            $display("FAIL at_valids: b=%b r=%b required b=1 r=%b", b_valid, r_valid, exp_r);
        end
        total++;
        if ({b_id, b_resp} !== {id, er}) begin
            bad++;
            $display("FAIL at_b: got id=%0d resp=%0d required id=%0d resp=%0d", b_id, b_resp, id, er);
        end
        if (exp_r) begin
            total++;
            if ({r_id, r_resp, r_last} !== {id, er, 1'b1}) begin
                bad++;
                $display("FAIL at_r_ctl: got id=%0d resp=%0d last=%b required id=%0d resp=%0d last=1",
                         r_id, r_resp, r_last, id, er);
            end
            if (er == 2'd0) begin
                total++;
                if (r_data !== ed) begin
                    bad++;
                    $display("FAIL at_r_data: got %h required %h", r_data, ed);
                end
            end
        end
        @(posedge clk); #1;
        b_ready = 0; r_ready = 0;
        @(negedge clk); #1;
        total++;
        if ({b_valid, r_valid} !== 2'b00) begin
            bad++;
            $display("FAIL at_done: b=%b r=%b required 0 0", b_valid, r_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (all_outs() !== 146'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        aw_valid = 1; ar_valid = 1;
        #1;
        total++;
        if ({aw_ready, ar_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b required 00", {aw_ready, ar_ready});
        end
        @(negedge clk);
        idle_inputs();
        rst = 0;
        #1;
        total++;
        if (all_outs() !== 146'd0) begin
            bad++;
            $display("FAIL idle_outputs: got %h required 0", all_outs());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) wr_burst(4'(i), 64'(i * 4096), 8'd255, 256, 0, 0);
    endtask

    task automatic test_basic();
        wr_burst(4'd3, 64'h40, 8'd3, 4, 1, 0);
        rd_burst(4'd5, 64'h40, 8'd3, 0);
    endtask

    task automatic test_arbitration();
        int g [4];
        int ng = 0;
        int both = 0;
        logic [127:0] d;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        d = rnd128();
        aw_valid = 1; aw_id = 4'd1; aw_addr = 64'h200; aw_len = 0; aw_atop = 0;
        ar_valid = 1; ar_id = 4'd2; ar_addr = 64'h300; ar_len = 0;
        w_valid = 1; w_data = d; w_strb = 16'hFFFF; w_last = 1;
        b_ready = 1; r_ready = 1;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (aw_ready && ar_ready) both++;
            if (ar_ready) begin g[ng] = 1; ng++; end
            else if (aw_ready) begin g[ng] = 0; ng++; end
            if (r_valid) begin
                total++;
                if ({r_data, r_id, r_resp, r_last} !== {ref_mem[48], 4'd2, 2'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL arb_r: got %h id=%0d required %h id=2", r_data, r_id, ref_mem[48]);
                end
            end
            if (b_valid) begin
                total++;
                if ({b_id, b_resp} !== {4'd1, 2'd0}) begin
                    bad++;
                    $display("FAIL arb_b: got id=%0d resp=%0d required id=1 resp=0", b_id, b_resp);
                end
                ref_mem[32] = d;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        aw_valid = 0; ar_valid = 0;
        repeat (8) @(negedge clk);
        idle_inputs();
        ref_mem[32] = d;
        total++;
        if (ng != 4 || both != 0) begin
            bad++;
            $display("FAIL arb_count: grants=%0d both=%0d required 4 and 0", ng, both);
        end
        for (int i = 0; i < 4 && i < ng; i++) begin
            total++;
            if (g[i] != ((i % 2 == 0) ? 1 : 0)) begin
                bad++;
                $display("FAIL arb_order grant %0d: got %s required %s", i,
                         g[i] == 1 ? "AR" : "AW", (i % 2 == 0) ? "AR" : "AW");
            end
        end
        rd_burst(4'd2, 64'h200, 8'd0, 0);
    endtask

    task automatic test_backpressure();
        rd_burst(4'd7, 64'h1230, 8'd7, 1);
        rd_burst(4'd8, 64'h2004, 8'd15, 2);
    endtask

    task automatic test_random();
        logic [7:0] len;
        logic [63:0] addr;
        logic [3:0] id;
        for (int it = 0; it < 24; it++) begin
            len = 8'($urandom_range(0, 7));
            id = 4'($urandom);
            addr = 64'($urandom_range(0, MW - 9)) * 16 + 64'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) wr_burst(id, addr, len, int'(len) + 1, 0, 1);
            else rd_burst(id, addr, len, 2);
        end
    endtask

    task automatic test_len_mismatch();
        wr_burst(4'd4, 64'h800, 8'd3, 2, 0, 0);
        wr_burst(4'd5, 64'h900, 8'd3, 5, 0, 0);
        rd_burst(4'd6, 64'h800, 8'd1, 0);
        rd_burst(4'd6, 64'h900, 8'd4, 0);
    endtask

    task automatic test_atomic();
        logic [127:0] old, wd, nw;
        logic [15:0] s;
        logic [63:0] lane0;
        lane0 = {$urandom, $urandom};
        aw_send(4'd1, 64'h100, 8'd0, 6'd0);
        w_send({64'hFFFF_FFFF_FFFF_FFFF, lane0}, 16'hFFFF, 1'b1);
        b_recv(4'd1, 2'd0);
        ref_mem[16] = {64'hFFFF_FFFF_FFFF_FFFF, lane0};
        old = ref_mem[16];
        atomic_chk(4'd6, 64'h108, 6'b100000, 8'd0, {64'd2, 64'($urandom)},
                   16'($urandom), 2'd0, 1, old);
        ref_mem[16][127:64] = 64'd1;
        rd_burst(4'd6, 64'h100, 8'd0, 0);
        old = ref_mem[40];
        wd = {64'd0, 64'h8000_0000_0000_0001};
        atomic_chk(4'd2, 64'h280, 6'b100000, 8'd0, wd, 16'h0, 2'd0, 1, old);
        ref_mem[40][63:0] = old[63:0] + 64'h8000_0000_0000_0001;
        rd_burst(4'd2, 64'h280, 8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            old = ref_mem[100 + i];
            wd = rnd128();
            s = 16'($urandom);
            nw = old;
            for (int b = 0; b < 16; b++) if (s[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
            atomic_chk(4'(9 + i), 64'(16 * (100 + i)), 6'b110000, 8'd0, wd, s, 2'd0, 1, old);
            ref_mem[100 + i] = nw;
            rd_burst(4'd9, 64'(16 * (100 + i)), 8'd0, 0);
        end
        atomic_chk(4'd12, 64'h500, 6'b110001, 8'd0, rnd128(), 16'hFFFF, 2'd2, 1, 128'd0);
        rd_burst(4'd12, 64'h500, 8'd0, 0);
        atomic_chk(4'd13, 64'h510, 6'b010000, 8'd0, rnd128(), 16'hFFFF, 2'd2, 0, 128'd0);
        atomic_chk(4'd14, 64'h520, 6'b110000, 8'd1, rnd128(), 16'hFFFF, 2'd2, 1, 128'd0);
        rd_burst(4'd13, 64'h510, 8'd1, 0);
    endtask

    task automatic test_oor();
        rd_burst(4'd7, 64'(MW * 16 - 16), 8'd1, 0);
        wr_burst(4'd2, 64'(MW * 16 - 16), 8'd1, 2, 0, 0);
        rd_burst(4'd3, 64'(MW * 16 - 16), 8'd0, 0);
        rd_burst(4'd3, 64'h0, 8'd0, 0);
        rd_burst(4'd4, 64'h1_0000_0000, 8'd0, 0);
    endtask

    task automatic test_reset_midburst();
        ar_send(4'd9, 64'h80, 8'd3);
        r_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if ({r_valid, r_data} !== {1'b1, ref_mem[10]}) begin
            bad++;
            $display("FAIL mid_beat2: got valid=%b data=%h required 1 %h", r_valid, r_data, ref_mem[10]);
        end
        rst = 1;
        #1;
        total++;
        if (all_outs() !== 146'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h required 0", all_outs());
        end
        @(negedge clk);
        r_ready = 0;
        rst = 0;
        @(negedge clk); #1;
        total++;
        if ({b_valid, r_valid} !== 2'b00) begin
            bad++;
            $display("FAIL mid_after_reset: b=%b r=%b required 0 0", b_valid, r_valid);
        end
        rd_burst(4'd10, 64'h80, 8'd3, 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_fill();
        test_basic();
        test_arbitration();
        test_backpressure();
        test_random();
        test_len_mismatch();
        test_atomic();
        test_oor();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 (ATOP) responder at the memory end of the CVA6 NoC port: 128-bit data, 4-bit ID, 64-bit address.
- Backs an internal word array and serves one transaction at a time: INCR bursts, single-beat AtomicSwap/AtomicLoad-ADD. Used as bench/FPGA main memory behind the HPDcache.

Parameters:
- AxiIdWidth, 4, width of all ID fields
- AxiAddrWidth, 64, width of aw/ar address
- MemWords, 1024, number of 128-bit storage words (power of two)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- aw_valid_i  in  1  write-address valid
- aw_ready_o  out  1  write-address ready
- aw_id_i  in  AxiIdWidth  write ID
- aw_addr_i  in  AxiAddrWidth  write start byte address
- aw_len_i  in  8  beats minus one (INCR only)
- aw_atop_i  in  6  AXI5 atomic opcode, 0 = normal write
- w_valid_i  in  1  write-data valid
- w_ready_o  out  1  write-data ready
- w_data_i  in  128  write data
- w_strb_i  in  16  byte strobes
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write-response valid
- b_ready_i  in  1  write-response ready
- b_id_o  out  AxiIdWidth  echoed aw_id
- b_resp_o  out  2  OKAY=0, SLVERR=2, DECERR=3
- ar_valid_i  in  1  read-address valid
- ar_ready_o  out  1  read-address ready
- ar_id_i  in  AxiIdWidth  read ID
- ar_addr_i  in  AxiAddrWidth  read start byte address
- ar_len_i  in  8  beats minus one (INCR only)
- r_valid_o  out  1  read-data valid
- r_ready_i  in  1  read-data ready
- r_id_o  out  AxiIdWidth  echoed ar_id/aw_id
- r_data_o  out  128  read data
- r_resp_o  out  2  read response
- r_last_o  out  1  last read beat

Behaviour:
- Reset: FSM=IDLE; all ready/valid outputs 0, ids/resp/data/last 0; read-priority flag = read-first; memory contents not reset. Reset mid-burst abandons the transaction, no response issued.
- FSM: IDLE, WR, BRESP, RD, ATW, ATRESP. In IDLE, aw_ready_o/ar_ready_o = combinational grant. If only one valid, grant it; if both, grant the side not granted last (read first after reset). At most one ready high per cycle.
- Word index = addr[log2(MemWords)+3:4], +1 per beat. Beats with address >= MemWords*16 get DECERR: writes dropped, read data 0. Low 4 address bits ignored for normal accesses.
- AW handshake, atop=0 -> WR: w_ready_o=1, each beat writes enabled bytes; on w_last_i -> BRESP. b_valid_o=1, held until b_ready_i, then IDLE. b_resp = worst error of any beat. w_last_i mismatching aw_len -> SLVERR, and WR still ends on w_last_i.
- AR handshake -> RD: first r_valid_o exactly 1 cycle after handshake. Outputs held stable while r_valid_o & !r_ready_i. Next beat presented the cycle after each accepted beat. r_last_o on beat ar_len; IDLE after it is accepted.
- AW handshake, atop!=0 -> ATW: accept exactly one W beat. Swap (6'b110000): R returns old word, enabled bytes overwritten. LoadAdd (6'b100000): 64-bit lane addr[3], old lane value returned in R, lane <= old + w lane mod 2^64. Strobes ignored for LoadAdd. Any other atop, or aw_len!=0: no memory update, SLVERR. R beat issued iff atop[5]=1; AtomicStore (atop[5:4]=01) gets B only.
- ATRESP: b_valid_o and r_valid_o (if required) asserted together with same id and resp, r_last_o=1. Each dropped independently on its own ready; IDLE when both done.

Test Plan:
- Reset, AW id=3 addr=0x40 len=3 + 4 beats of 0xA..D full strobe, then AR id=5 same addr len=3 -> B OKAY id 3; R 0xA..0xD, id 5, r_last only on beat 4, first beat 1 cycle after AR handshake.
- Same-cycle AW and AR valid after reset, repeated twice -> AR granted first, then AW, then AR (alternation).
- Read with r_ready_i low 3 cycles mid-burst -> r_data/r_id/r_last stable throughout, no beat lost or duplicated.
- AtomicLoad-ADD addr 0x108 (lane 1) with old 0xFFFF_FFFF_FFFF_FFFF, w lane 2 -> R data lane = all-ones, memory lane = 1, B and R both OKAY.
- AR addr MemWords*16-16 len=1 -> beat0 OKAY, beat1 DECERR data 0; aw_atop=6'b110001 (Compare) -> B and R SLVERR, memory unchanged.
- Assert rst_i during beat 2 of a 4-beat read -> all outputs 0 next cycle, next AR served normally.
